muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 171 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 32-bit signed multiply/divide sequencer for a MIPS-style HI/LO unit.
// MULT uses 32 shift-add steps on a 64-bit magnitude accumulator. DIV uses 32 restoring
// shift-subtract steps. A final FIX cycle applies the sign correction.
// Optional feature: define MULDIV_DIVZERO_CHECK_EN to short-circuit DIV by zero
// (IDLE->DONE, divZero pulse, no HI/LO write). By default divZero is tied to 0.
module muldiv_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        writeHI,
  output logic        writeLO,
  output logic        divZero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t      r_state;
  logic        r_op;
  logic        r_sign_a;
  logic        r_sign_b;
  logic [31:0] r_mag_a;
  logic [31:0] r_mag_b;
  // MULT: {partial product high, multiplier/product low}; DIV: {remainder, quotient}
  logic [63:0] r_acc;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_wr_hi;
  logic        r_wr_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
`ifdef MULDIV_DIVZERO_CHECK_EN
  logic        r_div_zero;
`endif

  logic [31:0] w_mag_a_in;
  logic [31:0] w_mag_b_in;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_shift;
  logic [32:0] w_div_diff;
  logic [63:0] w_div_next;
  logic [63:0] w_iter_next;
  logic        w_res_neg;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  // Operand magnitudes; 0x80000000 maps to itself, which is the correct unsigned magnitude
  assign w_mag_a_in = a[31] ? (~a + 32'd1) : a;
  assign w_mag_b_in = b[31] ? (~b + 32'd1) : b;

  // Shift-add step: conditionally add multiplicand to the upper half, then shift right
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mag_a} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // Restoring step: shift next dividend bit into the remainder, keep the difference if no borrow
  assign w_div_shift = {r_acc[63:32], r_acc[31]};
  assign w_div_diff  = w_div_shift - {1'b0, r_mag_b};
  assign w_div_next  = w_div_diff[32] ? {w_div_shift[31:0], r_acc[30:0], 1'b0}
                                      : {w_div_diff[31:0],  r_acc[30:0], 1'b1};

  assign w_iter_next = r_op ? w_div_next : w_mul_next;

  // Sign correction: product/quotient negative when signs differ, remainder follows dividend
  assign w_res_neg  = r_sign_a ^ r_sign_b;
  assign w_prod_fix = w_res_neg ? (~r_acc + 64'd1) : r_acc;
  assign w_quo_fix  = w_res_neg ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_rem_fix  = r_sign_a ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

  assign busy    = r_busy;
  assign done    = r_done;
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign writeHI = r_wr_hi;
  assign writeLO = r_wr_lo;
`ifdef MULDIV_DIVZERO_CHECK_EN
  assign divZero = r_div_zero;
`else
  assign divZero = 1'b0;
`endif

  // Sequencer FSM with registered status strobes and HI/LO results
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_mag_a    <= 32'd0;
      r_mag_b    <= 32'd0;
      r_acc      <= 64'd0;
      r_cnt      <= 6'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_hi    <= 1'b0;
      r_wr_lo    <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
`ifdef MULDIV_DIVZERO_CHECK_EN
      r_div_zero <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_sign_a <= a[31];
            r_sign_b <= b[31];
            r_mag_a  <= w_mag_a_in;
            r_mag_b  <= w_mag_b_in;
            r_cnt    <= 6'd0;
            r_busy   <= 1'b1;
`ifdef MULDIV_DIVZERO_CHECK_EN
            if (op && (b == 32'd0)) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_div_zero <= 1'b1;
            end else
`endif
            begin
              r_state <= S_RUN;
              // MULT seeds the low half with |b|; DIV seeds the quotient half with |a|
              r_acc   <= op ? {32'd0, w_mag_a_in} : {32'd0, w_mag_b_in};
            end
          end
        end
        S_RUN: begin
          r_acc <= w_iter_next;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_wr_hi <= 1'b1;
          r_wr_lo <= 1'b1;
          if (r_op) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[63:32];
            r_lo <= w_prod_fix[31:0];
          end
        end
        S_DONE: begin
          // start seen here is intentionally dropped; IDLE accepts it next cycle
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_wr_hi <= 1'b0;
          r_wr_lo <= 1'b0;
`ifdef MULDIV_DIVZERO_CHECK_EN
          r_div_zero <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer (default build or MULDIV_DIVZERO_CHECK_EN).
module tb_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        writeHI;
  logic        writeLO;
  logic        divZero;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_sequencer dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .writeHI (writeHI),
    .writeLO (writeLO),
    .divZero (divZero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run_op(input string tag, input logic o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat,
                        input logic exp_wr, input logic exp_dz);
    launch(o, x, y);
    chk({tag, " busy"}, 64'(busy), 64'd1);
    wait_done(tag, exp_lat);
    chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
    chk({tag, " writeHI"}, 64'(writeHI), 64'(exp_wr));
    chk({tag, " writeLO"}, 64'(writeLO), 64'(exp_wr));
    chk({tag, " divZero"}, 64'(divZero), 64'(exp_dz));
    tick();
    chk({tag, " done pulse"}, 64'(done), 64'd0);
    chk({tag, " writeHI pulse"}, 64'(writeHI), 64'd0);
    chk({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int strobes;
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) tick();
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    chk("rst writeHI", 64'(writeHI), 64'd0);
    chk("rst writeLO", 64'(writeLO), 64'd0);
    chk("rst divZero", 64'(divZero), 64'd0);
    reset = 1'b0;
    tick();

    run_op("mul_n3x7",    1'b0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b1, 1'b0);
    run_op("mul_shift",   1'b0, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 33, 1'b1, 1'b0);
    run_op("mul_minmin",  1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 1'b1, 1'b0);
    run_op("mul_m1m1",    1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33, 1'b1, 1'b0);
    run_op("div_n7_2",    1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b1, 1'b0);
    run_op("div_ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b1, 1'b0);
    run_op("div_100_n7",  1'b1, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 33, 1'b1, 1'b0);
    run_op("div_n100_n7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 33, 1'b1, 1'b0);
`ifdef MULDIV_DIVZERO_CHECK_EN
    run_op("div5_0",      1'b1, 32'h00000005, 32'h00000000, 32'hFFFFFFFE, 32'h0000000E, 0, 1'b0, 1'b1);
    run_op("divn5_0",     1'b1, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFE, 32'h0000000E, 0, 1'b0, 1'b1);
`else
    run_op("div5_0",      1'b1, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 33, 1'b1, 1'b0);
    run_op("divn5_0",     1'b1, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'h00000001, 33, 1'b1, 1'b0);
`endif

    // start pulses while busy and in DONE are dropped; the following cycle accepts
    launch(1'b1, 32'hFFFFFFF9, 32'h00000002);
    repeat (4) tick();
    op = 1'b0; a = 32'd3; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign_busy", 28);
    chk("ign_busy hi", 64'(hi), 64'hFFFFFFFF);
    chk("ign_busy lo", 64'(lo), 64'hFFFFFFFD);
    op = 1'b0; a = 32'd6; b = 32'd7; start = 1'b1;
    tick();
    chk("ign_done busy", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    chk("accept_after_done busy", 64'(busy), 64'd1);
    wait_done("accept_after_done", 33);
    chk("accept_after_done hi", 64'(hi), 64'd0);
    chk("accept_after_done lo", 64'(lo), 64'd42);
    tick();

    // reset mid-operation aborts without any strobe
    launch(1'b0, 32'd5, 32'd5);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort writeLO", 64'(writeLO), 64'd0);
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1 || writeHI === 1'b1 || writeLO === 1'b1) strobes++;
    end
    chk("abort no strobes", 64'(strobes), 64'd0);
    run_op("mul_after_rst", 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 33, 1'b1, 1'b0);

    // reset wins over a simultaneous start
    reset = 1'b1; op = 1'b0; a = 32'd2; b = 32'd2; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("rst_prio busy", 64'(busy), 64'd0);
    tick();
    chk("rst_prio busy2", 64'(busy), 64'd0);
    chk("rst_prio lo", 64'(lo), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
